// File: rtl/change_pkg.sv
// Shared definitions for the change dispenser: coin codes, coin values in cents,
// and the payout state encoding.
package change_pkg;

   typedef enum logic [1:0] {
      COIN_NICKEL  = 2'd0,
      COIN_DIME    = 2'd1,
      COIN_QUARTER = 2'd2,
      COIN_DOLLAR  = 2'd3
   } coin_t;

   localparam logic [15:0] VAL_NICKEL  = 16'd5;
   localparam logic [15:0] VAL_DIME    = 16'd10;
   localparam logic [15:0] VAL_QUARTER = 16'd25;
   localparam logic [15:0] VAL_DOLLAR  = 16'd100;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SELECT  = 3'd1,
      ST_PRESENT = 3'd2,
      ST_GAP     = 3'd3,
      ST_FINISH  = 3'd4,
      ST_FAULT   = 3'd5
   } state_t;

endpackage

// File: rtl/coin_selector.sv
// Greedy coin choice: the largest coin that does not exceed the amount still owed.
module coin_selector
   import change_pkg::*;
(
   input  logic [15:0] i_remaining,
   output coin_t       o_coinType,
   output logic [15:0] o_coinValue,
   output logic        o_noneFits
);

   always_comb begin
      o_coinType  = COIN_NICKEL;
      o_coinValue = VAL_NICKEL;
      o_noneFits  = 1'b0;
      if (i_remaining >= VAL_DOLLAR) begin
         o_coinType  = COIN_DOLLAR;
         o_coinValue = VAL_DOLLAR;
      end else if (i_remaining >= VAL_QUARTER) begin
         o_coinType  = COIN_QUARTER;
         o_coinValue = VAL_QUARTER;
      end else if (i_remaining >= VAL_DIME) begin
         o_coinType  = COIN_DIME;
         o_coinValue = VAL_DIME;
      end else if (i_remaining < VAL_NICKEL) begin
         o_coinValue = 16'd0;
         o_noneFits  = 1'b1;
      end
   end

endmodule

// File: rtl/change_dispenser.sv
// Pays out a change amount one coin at a time to a hopper over a valid/ack
// handshake, reporting completion, unpayable residual and hopper timeouts.
module change_dispenser
   import change_pkg::*;
#(
   parameter int ACK_TIMEOUT = 64,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [15:0]      change_in,
   input  logic             start,
   input  logic             coin_ack,
   output logic             coin_valid,
   output logic [1:0]       coin_type,
   output logic             busy,
   output logic             done,
   output logic             short_pay,
   output logic [15:0]      remaining,
   output logic [CNT_W-1:0] coin_count,
   output logic             fault
);

   localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

   state_t             r_state;
   coin_t              r_coinType;
   logic [15:0]        r_coinValue;
   logic [15:0]        r_remaining;
   logic [CNT_W-1:0]   r_coinCount;
   logic [TMR_W-1:0]   r_timer;
   logic               r_coinValid;
   logic               r_busy;
   logic               r_done;
   logic               r_shortPay;
   logic               r_fault;

   coin_t              w_selType;
   logic [15:0]        w_selValue;
   logic               w_noneFits;

   coin_selector u_selector (
      .i_remaining (r_remaining),
      .o_coinType  (w_selType),
      .o_coinValue (w_selValue),
      .o_noneFits  (w_noneFits)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_coinType  <= COIN_NICKEL;
         r_coinValue <= '0;
         r_remaining <= '0;
         r_coinCount <= '0;
         r_timer     <= '0;
         r_coinValid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_shortPay  <= 1'b0;
         r_fault     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_remaining <= change_in;
                  r_coinCount <= '0;
                  r_shortPay  <= 1'b0;
                  r_busy      <= 1'b1;
                  r_state     <= ST_SELECT;
               end
            end
            ST_SELECT: begin
               if (w_noneFits) begin
                  r_done     <= 1'b1;
                  r_busy     <= 1'b0;
                  r_shortPay <= (r_remaining != 16'd0);
                  r_state    <= ST_FINISH;
               end else begin
                  r_coinType  <= w_selType;
                  r_coinValue <= w_selValue;
                  r_coinValid <= 1'b1;
                  r_timer     <= '0;
                  r_state     <= ST_PRESENT;
               end
            end
            ST_PRESENT: begin
               // The selected coin never exceeds the amount owed, so no underflow here.
               if (r_coinValid && coin_ack) begin
                  r_remaining <= r_remaining - r_coinValue;
                  if (r_coinCount != '1)
                     r_coinCount <= r_coinCount + 1'b1;
                  r_timer     <= '0;
                  r_coinValid <= 1'b0;
                  r_state     <= ST_GAP;
               end else if (r_timer == TMR_W'(ACK_TIMEOUT - 1)) begin
                  r_coinValid <= 1'b0;
                  r_fault     <= 1'b1;
                  r_state     <= ST_FAULT;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            ST_GAP: begin
               r_state <= ST_SELECT;
            end
            ST_FINISH: begin
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
            ST_FAULT: begin
               r_state <= ST_FAULT;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign coin_valid = r_coinValid;
   assign coin_type  = r_coinType;
   assign busy       = r_busy;
   assign done       = r_done;
   assign short_pay  = r_shortPay;
   assign remaining  = r_remaining;
   assign coin_count = r_coinCount;
   assign fault      = r_fault;

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized scoreboard bench for change_dispenser: a greedy arithmetic model predicts
// coin sequences and final results, and a monitor checks them as the DUT emits them.
module tb_change_dispenser;

   localparam int TO    = 16;
   localparam int CNT_W = 8;

   localparam int ACK_OFF     = 0;
   localparam int ACK_TIED    = 1;
   localparam int ACK_DELAYED = 2;
   localparam int ACK_RANDOM  = 3;

   typedef struct {
      int count;
      int rem;
      int shortPay;
   } res_t;

   logic             clk;
   logic             reset;
   logic [15:0]      change_in;
   logic             start;
   logic             coin_ack;
   logic             coin_valid;
   logic [1:0]       coin_type;
   logic             busy;
   logic             done;
   logic             short_pay;
   logic [15:0]      remaining;
   logic [CNT_W-1:0] coin_count;
   logic             fault;

   int   total = 0;
   int   bad   = 0;
   int   ackMode = ACK_OFF;
   bit   prevValid = 1'b0;
   bit   sawValid = 1'b0;
   bit   expectFault = 1'b0;
   bit   faultReported = 1'b0;
   int   coinQ[$];
   res_t resQ[$];

   change_dispenser #(.ACK_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .change_in  (change_in),
      .start      (start),
      .coin_ack   (coin_ack),
      .coin_valid (coin_valid),
      .coin_type  (coin_type),
      .busy       (busy),
      .done       (done),
      .short_pay  (short_pay),
      .remaining  (remaining),
      .coin_count (coin_count),
      .fault      (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Greedy payout computed by whole-coin division of the amount.
   task automatic pushModel(input int c);
      int r, nd, nq, ni, nn, n;
      res_t res;
      nd = c / 100;  r = c % 100;
      nq = r / 25;   r = r % 25;
      ni = r / 10;   r = r % 10;
      nn = r / 5;    r = r % 5;
      for (int k = 0; k < nd; k++) coinQ.push_back(3);
      for (int k = 0; k < nq; k++) coinQ.push_back(2);
      for (int k = 0; k < ni; k++) coinQ.push_back(1);
      for (int k = 0; k < nn; k++) coinQ.push_back(0);
      n = nd + nq + ni + nn;
      res.count    = (n > 255) ? 255 : n;
      res.rem      = r;
      res.shortPay = (r != 0) ? 1 : 0;
      resQ.push_back(res);
   endtask

   // Hopper model: drives coin_ack shortly after each rising edge.
   always @(posedge clk) begin
      #1;
      case (ackMode)
         ACK_TIED:    coin_ack = 1'b1;
         ACK_DELAYED: coin_ack = coin_valid && prevValid;
         ACK_RANDOM:  coin_ack = ($urandom_range(0, 2) == 0);
         default:     coin_ack = 1'b0;
      endcase
      prevValid = coin_valid;
   end

   // Monitor: pops expected coins on each handshake and expected results on done.
   always @(negedge clk) begin
      if (reset) begin
         if (coin_valid) sawValid = 1'b1;
         if (coin_valid && coin_ack) begin
            if (coinQ.size() == 0) begin
               checkOutput("unexpected_coin", 1, 0);
            end else begin
               checkOutput("coin_type", coin_type, coinQ.pop_front());
            end
         end
         if (done) begin
            if (resQ.size() == 0) begin
               checkOutput("unexpected_done", 1, 0);
            end else begin
               res_t r;
               r = resQ.pop_front();
               checkOutput("coin_count", coin_count, r.count);
               checkOutput("remaining", remaining, r.rem);
               checkOutput("short_pay", short_pay, r.shortPay);
               checkOutput("busy_at_done", busy, 0);
            end
         end
         if (fault && !expectFault && !faultReported) begin
            faultReported = 1'b1;
            checkOutput("unexpected_fault", fault, 0);
         end
      end
   end

   task automatic applyStimulus(input int c, input int mode, output int doneCycles);
      int cyc;
      ackMode  = mode;
      sawValid = 1'b0;
      pushModel(c);
      @(negedge clk);
      change_in = 16'(c);
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      change_in = 16'($urandom);
      checkOutput("busy_after_start", busy, 1);
      checkOutput("short_pay_cleared", short_pay, 0);
      checkOutput("done_early", done, 0);
      cyc = 0;
      while (!done && cyc < 5000) begin
         @(negedge clk);
         cyc++;
      end
      if (!done) begin
         checkOutput("done_timeout", cyc, -1);
         coinQ.delete();
         resQ.delete();
      end
      doneCycles = cyc;
      @(negedge clk);
      checkOutput("coins_left", coinQ.size(), 0);
      checkOutput("done_width", done, 0);
   endtask

   initial begin
      int cyc;
      int validCycles;
      reset     = 1'b1;
      start     = 1'b0;
      change_in = '0;
      #2 reset  = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_coin_valid", coin_valid, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_remaining", remaining, 0);
      checkOutput("rst_coin_count", coin_count, 0);
      checkOutput("rst_fault", fault, 0);
      reset = 1'b1;

      applyStimulus(50, ACK_TIED, cyc);
      applyStimulus(175, ACK_DELAYED, cyc);

      applyStimulus(0, ACK_TIED, cyc);
      checkOutput("zero_done_latency", cyc, 1);
      checkOutput("zero_no_valid", sawValid, 0);

      applyStimulus(42, ACK_TIED, cyc);
      checkOutput("short_pay_held", short_pay, 1);
      checkOutput("residual_held", remaining, 2);

      for (int i = 0; i < 20; i++)
         applyStimulus($urandom_range(0, 999), $urandom_range(1, 3), cyc);

      applyStimulus(65535, ACK_TIED, cyc);

      $display("[TB] hopper timeout scenario");
      ackMode     = ACK_OFF;
      expectFault = 1'b1;
      @(negedge clk);
      change_in = 16'd100;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      validCycles = 0;
      cyc = 0;
      while (!fault && cyc < 200) begin
         if (coin_valid) begin
            validCycles++;
            checkOutput("fault_coin_type", coin_type, 3);
         end
         @(negedge clk);
         cyc++;
      end
      checkOutput("fault_valid_cycles", validCycles, TO);
      checkOutput("fault_flag", fault, 1);
      checkOutput("fault_coin_valid", coin_valid, 0);
      checkOutput("fault_remaining", remaining, 100);
      checkOutput("fault_busy", busy, 1);
      change_in = 16'd5;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("fault_start_ignored", remaining, 100);
      checkOutput("fault_sticky", fault, 1);
      checkOutput("fault_no_valid", coin_valid, 0);
      reset = 1'b0;
      #1;
      checkOutput("fault_cleared", fault, 0);
      checkOutput("fault_rst_busy", busy, 0);
      @(posedge clk);
      #3 reset    = 1'b1;
      expectFault = 1'b0;

      $display("[TB] mid-transaction reset scenario");
      applyStimulus(25, ACK_TIED, cyc);
      ackMode  = ACK_TIED;
      pushModel(200);
      @(negedge clk);
      change_in = 16'd200;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (coin_count != 1 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      ackMode = ACK_OFF;
      checkOutput("first_coin_paid", coin_count, 1);
      cyc = 0;
      while (!coin_valid && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput("second_coin_presented", coin_valid, 1);
      #2 reset = 1'b0;
      #1;
      checkOutput("async_coin_valid", coin_valid, 0);
      checkOutput("async_busy", busy, 0);
      checkOutput("async_remaining", remaining, 0);
      checkOutput("async_coin_count", coin_count, 0);
      checkOutput("async_short_pay", short_pay, 0);
      checkOutput("async_done", done, 0);
      coinQ.delete();
      resQ.delete();
      @(posedge clk);
      #3 reset = 1'b1;

      applyStimulus(35, ACK_RANDOM, cyc);
      applyStimulus(9, ACK_DELAYED, cyc);

      $display("[TB] test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
